// File: rtl/shift_sched_pkg.sv
// Shared types and constants for the data_shift front-end scheduler.
package shift_sched_pkg;

  localparam int DATA_W  = 256;
  localparam int EMPTY_W = 5;

  localparam logic [7:0] PROT_TCP = 8'd6;
  localparam logic [7:0] PROT_UDP = 8'd17;

  typedef struct packed {
    logic [7:0]  prot;
    logic [15:0] pkt_len;
    logic [7:0]  flow_id;
  } metadata_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BODY   = 2'd1,
    BUBBLE = 2'd2
  } sched_state_t;

  // data_shift emits one trailing flit for a non-UDP EOP that carries fewer than 8 empty bytes
  function automatic logic needs_extra(input logic eop, input logic udp,
                                       input logic [EMPTY_W-1:0] empty);
    return eop & ~udp & (empty < EMPTY_W'(8));
  endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Packet, metadata and credit signals between the FIFOs, the scheduler and data_shift.
interface shift_sched_if
  import shift_sched_pkg::*;
#(
  parameter int CREDITS = 32
) ();
  localparam int CREDIT_W = $clog2(CREDITS + 1);

  logic                in_pkt_valid;
  logic                in_pkt_sop;
  logic                in_pkt_eop;
  logic [DATA_W-1:0]   in_pkt_data;
  logic [EMPTY_W-1:0]  in_pkt_empty;
  logic                in_pkt_ready;
  logic                in_meta_valid;
  metadata_t           in_meta_data;
  logic                in_meta_ready;

  logic                out_pkt_valid;
  logic                out_pkt_sop;
  logic                out_pkt_eop;
  logic [DATA_W-1:0]   out_pkt_data;
  logic [EMPTY_W-1:0]  out_pkt_empty;
  logic                out_meta_valid;
  metadata_t           out_meta_data;

  logic                credit_return;
  logic [CREDIT_W-1:0] credit_cnt;
  logic                credit_err;

  modport slave (
    input  in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty,
    input  in_meta_valid, in_meta_data, credit_return,
    output in_pkt_ready, in_meta_ready,
    output out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_data, out_pkt_empty,
    output out_meta_valid, out_meta_data, credit_cnt, credit_err
  );

  modport master (
    output in_pkt_valid, in_pkt_sop, in_pkt_eop, in_pkt_data, in_pkt_empty,
    output in_meta_valid, in_meta_data, credit_return,
    input  in_pkt_ready, in_meta_ready,
    input  out_pkt_valid, out_pkt_sop, out_pkt_eop, out_pkt_data, out_pkt_empty,
    input  out_meta_valid, out_meta_data, credit_cnt, credit_err
  );

endinterface

// File: rtl/shift_credit_ctr.sv
// Downstream credit counter: saturates at CREDITS, flags overflowing returns,
// and reports whether the flit on offer fits in the remaining credits.
module shift_credit_ctr #(
  parameter  int CREDITS  = 32,
  localparam int CREDIT_W = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                extra,
  input  logic                credit_return,
  output logic [CREDIT_W-1:0] credit_cnt,
  output logic                credit_err,
  output logic                can_issue
);

  logic [CREDIT_W:0]   need;
  logic [CREDIT_W-1:0] dec;
  logic [CREDIT_W-1:0] cnt_next;
  logic                overflow;

  always_comb begin
    need      = (CREDIT_W + 1)'(1) + (CREDIT_W + 1)'(extra);
    can_issue = ({1'b0, credit_cnt} >= need);
    dec       = accept ? CREDIT_W'(need) : '0;
    overflow  = credit_return & ~accept & (credit_cnt == CREDIT_W'(CREDITS));
    // accept never exceeds the count and a return only lands below full, so no wrap
    cnt_next  = credit_cnt - dec + CREDIT_W'(credit_return & ~overflow);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CREDIT_W'(CREDITS);
      credit_err <= 1'b0;
    end else begin
      credit_cnt <= cnt_next;
      if (overflow) credit_err <= 1'b1;
    end
  end

endmodule

// File: rtl/shift_sched.sv
// Pairs SOP flits with metadata, throttles on downstream credits and inserts the
// idle cycle data_shift needs after a flit that makes it emit a trailing flit.
//   state  | meaning
//   IDLE   | waiting for SOP with metadata
//   BODY   | inside a packet
//   BUBBLE | one forced idle cycle
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int CREDITS = 32
) (
  input logic           clk,
  input logic           rst,
  shift_sched_if.slave  bus
);

  sched_state_t        state, state_next;
  logic                udp_l, udp_l_next;
  logic                udp, extra, can_issue;
  logic                ready, accept, sop_accept;

  logic                o_valid, o_sop, o_eop, o_meta_valid;
  logic [DATA_W-1:0]   o_data;
  logic [EMPTY_W-1:0]  o_empty;
  metadata_t           o_meta_data;

  always_comb begin
    udp        = (state == IDLE) ? (bus.in_meta_data.prot == PROT_UDP) : udp_l;
    extra      = needs_extra(bus.in_pkt_eop, udp, bus.in_pkt_empty);
    ready      = 1'b0;
    state_next = state;
    udp_l_next = udp_l;

    unique case (state)
      IDLE:    ready = bus.in_pkt_valid & bus.in_pkt_sop & bus.in_meta_valid & can_issue;
      BODY:    ready = can_issue;
      default: ready = 1'b0;
    endcase

    accept     = bus.in_pkt_valid & ready;
    sop_accept = ready & bus.in_pkt_sop & (state == IDLE);

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.in_pkt_eop) begin
            state_next = extra ? BUBBLE : IDLE;
          end else begin
            state_next = BODY;
            udp_l_next = udp;
          end
        end
      end
      BODY: begin
        if (accept && bus.in_pkt_eop) state_next = extra ? BUBBLE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      udp_l <= 1'b0;
    end else begin
      state <= state_next;
      udp_l <= udp_l_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid      <= 1'b0;
      o_sop        <= 1'b0;
      o_eop        <= 1'b0;
      o_data       <= '0;
      o_empty      <= '0;
      o_meta_valid <= 1'b0;
      o_meta_data  <= '0;
    end else begin
      o_valid      <= accept;
      o_sop        <= accept & bus.in_pkt_sop;
      o_eop        <= accept & bus.in_pkt_eop;
      o_meta_valid <= sop_accept;
      if (accept) begin
        o_data  <= bus.in_pkt_data;
        o_empty <= bus.in_pkt_empty;
      end
      if (sop_accept) o_meta_data <= bus.in_meta_data;
    end
  end

  shift_credit_ctr #(.CREDITS(CREDITS)) u_credit (
    .clk           (clk),
    .rst           (rst),
    .accept        (accept),
    .extra         (extra),
    .credit_return (bus.credit_return),
    .credit_cnt    (bus.credit_cnt),
    .credit_err    (bus.credit_err),
    .can_issue     (can_issue)
  );

  assign bus.in_pkt_ready   = ready;
  assign bus.in_meta_ready  = sop_accept;
  assign bus.out_pkt_valid  = o_valid;
  assign bus.out_pkt_sop    = o_sop;
  assign bus.out_pkt_eop    = o_eop;
  assign bus.out_pkt_data   = o_data;
  assign bus.out_pkt_empty  = o_empty;
  assign bus.out_meta_valid = o_meta_valid;
  assign bus.out_meta_data  = o_meta_data;

endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: one instance with 32 credits, one with 2.
module tb_shift_sched;
  import shift_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_sched_if #(.CREDITS(32)) ifa ();
  shift_sched_if #(.CREDITS(2))  ifb ();

  shift_sched #(.CREDITS(32)) dut  (.clk(clk), .rst(rst), .bus(ifa.slave));
  shift_sched #(.CREDITS(2))  dut2 (.clk(clk), .rst(rst), .bus(ifb.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input int n);
    logic [31:0] w;
    w = 32'hA5C3_0000 | 32'(n);
    return {8{w}};
  endfunction

  task automatic drv_a(input logic v, input logic s, input logic e, input logic [255:0] d,
                       input logic [4:0] emp, input logic mv, input logic [7:0] prot,
                       input logic ret);
    ifa.in_pkt_valid  = v;
    ifa.in_pkt_sop    = s;
    ifa.in_pkt_eop    = e;
    ifa.in_pkt_data   = d;
    ifa.in_pkt_empty  = emp;
    ifa.in_meta_valid = mv;
    ifa.in_meta_data  = '{prot: prot, pkt_len: 16'h0040, flow_id: 8'h11};
    ifa.credit_return = ret;
  endtask

  task automatic drv_b(input logic v, input logic s, input logic e, input logic [255:0] d,
                       input logic [4:0] emp, input logic mv, input logic [7:0] prot,
                       input logic ret);
    ifb.in_pkt_valid  = v;
    ifb.in_pkt_sop    = s;
    ifb.in_pkt_eop    = e;
    ifb.in_pkt_data   = d;
    ifb.in_pkt_empty  = emp;
    ifb.in_meta_valid = mv;
    ifb.in_meta_data  = '{prot: prot, pkt_len: 16'h0020, flow_id: 8'h22};
    ifb.credit_return = ret;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    drv_b(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", ifa.out_pkt_valid, 0);
    chk("rst_meta_valid", ifa.out_meta_valid, 0);
    chk("rst_credit", ifa.credit_cnt, 32);
    chk("rst_err", ifa.credit_err, 0);
    chk("rst_credit_b", ifb.credit_cnt, 2);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // TCP 3 flits, last empty=4: bubble follows, 4 credits consumed
    drv_a(1, 1, 0, pat(0), 0, 1, PROT_TCP, 0); #1;
    chk("s1_rdy_sop", ifa.in_pkt_ready, 1);
    chk("s1_mrdy_sop", ifa.in_meta_ready, 1);
    tick();
    chk("s1_o0_valid", ifa.out_pkt_valid, 1);
    chk("s1_o0_sop", ifa.out_pkt_sop, 1);
    chk("s1_o0_data", ifa.out_pkt_data, pat(0));
    chk("s1_o0_meta_valid", ifa.out_meta_valid, 1);
    chk("s1_o0_meta_prot", ifa.out_meta_data.prot, PROT_TCP);
    chk("s1_credit0", ifa.credit_cnt, 31);
    drv_a(1, 0, 0, pat(1), 0, 0, PROT_TCP, 0); #1;
    chk("s1_rdy_body", ifa.in_pkt_ready, 1);
    chk("s1_mrdy_body", ifa.in_meta_ready, 0);
    tick();
    chk("s1_o1_data", ifa.out_pkt_data, pat(1));
    chk("s1_o1_sop", ifa.out_pkt_sop, 0);
    chk("s1_o1_meta_valid", ifa.out_meta_valid, 0);
    chk("s1_credit1", ifa.credit_cnt, 30);
    // metadata bus now says UDP, but the packet was latched as TCP
    drv_a(1, 0, 1, pat(2), 4, 0, PROT_UDP, 0); #1;
    chk("s1_rdy_eop", ifa.in_pkt_ready, 1);
    tick();
    chk("s1_o2_valid", ifa.out_pkt_valid, 1);
    chk("s1_o2_eop", ifa.out_pkt_eop, 1);
    chk("s1_o2_empty", ifa.out_pkt_empty, 4);
    chk("s1_credit2", ifa.credit_cnt, 28);
    drv_a(1, 1, 1, pat(3), 8, 1, PROT_UDP, 0); #1;
    chk("s1_bubble_rdy", ifa.in_pkt_ready, 0);
    chk("s1_bubble_mrdy", ifa.in_meta_ready, 0);
    tick();
    chk("s1_bubble_out_valid", ifa.out_pkt_valid, 0);
    chk("s1_hold_data", ifa.out_pkt_data, pat(2));
    chk("s1_credit3", ifa.credit_cnt, 28);
    repeat (4) begin
      drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 1);
      tick();
    end
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0); #1;
    chk("s1_refill", ifa.credit_cnt, 32);
    chk("s1_no_err", ifa.credit_err, 0);

    // UDP 3 flits, empty=4: no bubble, next SOP back-to-back; then empty=8 vs 7
    drv_a(1, 1, 0, pat(10), 0, 1, PROT_UDP, 0); #1;
    chk("s2_rdy_sop", ifa.in_pkt_ready, 1);
    tick();
    chk("s2_meta_prot", ifa.out_meta_data.prot, PROT_UDP);
    chk("s2_credit0", ifa.credit_cnt, 31);
    drv_a(1, 0, 0, pat(11), 0, 0, PROT_TCP, 0);
    tick();
    drv_a(1, 0, 1, pat(12), 4, 0, PROT_TCP, 0); #1;
    chk("s2_rdy_eop", ifa.in_pkt_ready, 1);
    tick();
    chk("s2_o_eop", ifa.out_pkt_eop, 1);
    chk("s2_credit_eop", ifa.credit_cnt, 29);
    drv_a(1, 1, 1, pat(13), 8, 1, PROT_TCP, 0); #1;
    chk("s2_b2b_rdy", ifa.in_pkt_ready, 1);
    tick();
    chk("s2_b2b_valid", ifa.out_pkt_valid, 1);
    chk("s2_b2b_sop", ifa.out_pkt_sop, 1);
    chk("s3_e8_credit", ifa.credit_cnt, 28);
    drv_a(1, 1, 1, pat(14), 7, 1, PROT_TCP, 0); #1;
    chk("s3_e8_no_bubble", ifa.in_pkt_ready, 1);
    tick();
    chk("s3_e7_empty", ifa.out_pkt_empty, 7);
    chk("s3_e7_credit", ifa.credit_cnt, 26);
    drv_a(1, 1, 1, pat(15), 0, 1, PROT_TCP, 0); #1;
    chk("s3_e7_bubble", ifa.in_pkt_ready, 0);
    tick();
    chk("s3_bubble_out_valid", ifa.out_pkt_valid, 0);
    repeat (6) begin
      drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 1);
      tick();
    end
    chk("s3_refill", ifa.credit_cnt, 32);

    // SOP waits three cycles for metadata
    for (int i = 0; i < 3; i++) begin
      drv_a(1, 1, 1, pat(20), 0, 0, PROT_UDP, 0); #1;
      chk("s4_wait_rdy", ifa.in_pkt_ready, 0);
      chk("s4_wait_mrdy", ifa.in_meta_ready, 0);
      tick();
      chk("s4_wait_out_valid", ifa.out_pkt_valid, 0);
    end
    drv_a(1, 1, 1, pat(20), 0, 1, PROT_UDP, 0); #1;
    chk("s4_rdy", ifa.in_pkt_ready, 1);
    chk("s4_mrdy", ifa.in_meta_ready, 1);
    tick();
    chk("s4_out_sop", ifa.out_pkt_sop, 1);
    chk("s4_out_meta_valid", ifa.out_meta_valid, 1);
    chk("s4_credit", ifa.credit_cnt, 31);
    drv_a(0, 0, 0, '0, 0, 1, PROT_UDP, 0); #1;
    chk("s4_mrdy_once", ifa.in_meta_ready, 0);
    tick();
    chk("s4_meta_valid_drop", ifa.out_meta_valid, 0);

    // drain to low credit inside a long TCP packet
    drv_a(1, 1, 0, pat(30), 0, 1, PROT_TCP, 0);
    tick();
    for (int i = 0; i < 25; i++) begin
      drv_a(1, 0, 0, pat(31), 0, 0, PROT_TCP, 0);
      tick();
    end
    chk("s5_credit5", ifa.credit_cnt, 5);
    drv_a(1, 0, 0, pat(32), 0, 0, PROT_TCP, 1); #1;
    chk("s5_rdy5", ifa.in_pkt_ready, 1);
    tick();
    chk("s5_ret_and_accept", ifa.credit_cnt, 5);
    for (int i = 0; i < 4; i++) begin
      drv_a(1, 0, 0, pat(33), 0, 0, PROT_TCP, 0);
      tick();
    end
    chk("s5_credit1", ifa.credit_cnt, 1);
    drv_a(1, 0, 1, pat(34), 4, 0, PROT_TCP, 0); #1;
    chk("s5_need2_stall", ifa.in_pkt_ready, 0);
    tick();
    chk("s5_stall_out_valid", ifa.out_pkt_valid, 0);
    drv_a(1, 0, 1, pat(34), 4, 0, PROT_TCP, 1); #1;
    chk("s5_need2_stall_ret", ifa.in_pkt_ready, 0);
    tick();
    chk("s5_credit2", ifa.credit_cnt, 2);
    drv_a(1, 0, 1, pat(34), 4, 0, PROT_TCP, 0); #1;
    chk("s5_need2_go", ifa.in_pkt_ready, 1);
    tick();
    chk("s5_eop_valid", ifa.out_pkt_valid, 1);
    chk("s5_credit0", ifa.credit_cnt, 0);
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    tick();
    repeat (32) begin
      drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 1);
      tick();
    end
    chk("s5_full", ifa.credit_cnt, 32);
    chk("s5_full_no_err", ifa.credit_err, 0);

    // overflowing return
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 1);
    tick();
    chk("ovf_err", ifa.credit_err, 1);
    chk("ovf_credit_sat", ifa.credit_cnt, 32);
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    tick();
    chk("ovf_err_sticky", ifa.credit_err, 1);

    // reset mid-BODY
    drv_a(1, 1, 0, pat(40), 0, 1, PROT_TCP, 0);
    tick();
    chk("rb_pre_valid", ifa.out_pkt_valid, 1);
    drv_a(1, 0, 0, pat(41), 0, 0, PROT_TCP, 0);
    #1 rst = 1'b1;
    #1;
    chk("rb_out_valid", ifa.out_pkt_valid, 0);
    chk("rb_out_meta_valid", ifa.out_meta_valid, 0);
    chk("rb_out_data", ifa.out_pkt_data, 0);
    chk("rb_credit", ifa.credit_cnt, 32);
    chk("rb_err_clear", ifa.credit_err, 0);
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    drv_a(1, 0, 0, pat(42), 0, 1, PROT_TCP, 0); #1;
    chk("rb_idle_nonsop_stall", ifa.in_pkt_ready, 0);
    tick();
    chk("rb_idle_nonsop_out", ifa.out_pkt_valid, 0);
    drv_a(0, 0, 0, '0, 0, 0, PROT_TCP, 0);

    // two-credit instance
    drv_b(1, 1, 1, pat(50), 2, 1, PROT_TCP, 0); #1;
    chk("b_rdy_first", ifb.in_pkt_ready, 1);
    tick();
    chk("b_first_valid", ifb.out_pkt_valid, 1);
    chk("b_credit0", ifb.credit_cnt, 0);
    drv_b(1, 1, 1, pat(51), 0, 1, PROT_UDP, 0);
    tick();
    #1;
    chk("b_no_credit_rdy", ifb.in_pkt_ready, 0);
    tick();
    chk("b_no_credit_out", ifb.out_pkt_valid, 0);
    drv_b(1, 1, 1, pat(51), 0, 1, PROT_UDP, 1); #1;
    chk("b_ret_rdy", ifb.in_pkt_ready, 0);
    tick();
    chk("b_credit1", ifb.credit_cnt, 1);
    drv_b(1, 1, 1, pat(51), 0, 1, PROT_UDP, 0); #1;
    chk("b_udp_go", ifb.in_pkt_ready, 1);
    tick();
    chk("b_udp_valid", ifb.out_pkt_valid, 1);
    chk("b_credit_udp", ifb.credit_cnt, 0);
    drv_b(1, 1, 1, pat(52), 3, 1, PROT_TCP, 1); #1;
    chk("b_tcp_rdy0", ifb.in_pkt_ready, 0);
    tick();
    drv_b(1, 1, 1, pat(52), 3, 1, PROT_TCP, 1); #1;
    chk("b_tcp_one_credit", ifb.in_pkt_ready, 0);
    tick();
    chk("b_credit2", ifb.credit_cnt, 2);
    drv_b(1, 1, 1, pat(52), 3, 1, PROT_TCP, 0); #1;
    chk("b_tcp_go", ifb.in_pkt_ready, 1);
    tick();
    chk("b_tcp_valid", ifb.out_pkt_valid, 1);
    chk("b_tcp_data", ifb.out_pkt_data, pat(52));
    chk("b_credit_end", ifb.credit_cnt, 0);
    drv_b(0, 0, 0, '0, 0, 0, PROT_TCP, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_sched.md
Name: shift_sched

Overview:
- Sequences packet flits and metadata into data_shift.
- Pairs each SOP flit with its metadata word and throttles issue against downstream buffer credits. data_shift has no back-pressure, so this accounting is required.
- Inserts the mandatory idle cycle after any flit that makes data_shift emit an extra trailing flit.
- Sits between the packet/metadata FIFOs and data_shift. Its downstream credits come from the FIFO that data_shift feeds.

Parameters:
CREDITS, 32, downstream FIFO depth in flits; initial and maximum credit count
CREDIT_W, $clog2(CREDITS+1), credit counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_pkt_valid/sop/eop  in  1 each  upstream packet flit
in_pkt_data  in  256  flit data
in_pkt_empty  in  5  empty bytes on EOP flit
in_pkt_ready  out  1  flit accepted when valid&ready
in_meta_valid  in  1  metadata word present
in_meta_data  in  metadata_t  per-packet metadata
in_meta_ready  out  1  metadata pop; asserted only with SOP accept
out_pkt_valid/sop/eop  out  1 each  to data_shift
out_pkt_data  out  256  to data_shift
out_pkt_empty  out  5  to data_shift
out_meta_valid  out  1  to data_shift, coincident with out SOP
out_meta_data  out  metadata_t  to data_shift
credit_return  in  1  one pulse per flit popped from downstream FIFO
credit_cnt  out  CREDIT_W  current free credits (debug)
credit_err  out  1  sticky: return received while credit_cnt==CREDITS

Behaviour:
- Reset (async): all out_* = 0, credit_cnt = CREDITS, credit_err = 0, state IDLE, udp_l = 0.
- States:
  - IDLE: waiting for SOP.
  - BODY: inside packet.
  - BUBBLE: one forced idle cycle.
- extra(f) = f.eop & !udp & (f.empty < 8). Comparison is 5-bit unsigned; empty == 8 gives extra = 0.
- need(f) = 1 + extra(f).
- udp: IDLE uses in_meta_data.prot == PROT_UDP; BODY uses udp_l.
- in_pkt_ready (combinational from state and counters):
  - IDLE: in_pkt_valid & in_pkt_sop & in_meta_valid & (credit_cnt >= need).
  - BODY: credit_cnt >= need.
  - BUBBLE: 0.
- In IDLE a non-SOP flit is never accepted; it stalls.
- in_meta_ready = in_pkt_ready & in_pkt_sop & state==IDLE.
- Latency: accept at cycle t drives out_pkt_* at t+1, registered. out_meta_* registers on SOP accept with out_meta_valid=1; otherwise out_meta_valid=0.
- out_pkt_valid=0 on any cycle with no accept. Data/empty hold their value.
- Transitions:
  - IDLE, SOP&EOP accept: extra → BUBBLE, else stay IDLE.
  - IDLE, SOP-only accept: → BODY, latch udp_l.
  - BODY, EOP accept: extra → BUBBLE, else → IDLE.
  - BUBBLE → IDLE unconditionally after 1 cycle.
- Bubble rationale: accept at t puts the EOP into data_shift at t+1, and it emits the extra flit at t+2. Ready=0 at t+1 guarantees no input to data_shift at t+2.
- Credits: credit_cnt_next = credit_cnt − (accept ? need : 0) + credit_return.
  - Simultaneous accept and return are both applied.
  - A return at CREDITS with no accept is dropped and sets credit_err.
  - Underflow is impossible by the ready rule.
- SOP arriving in BODY (missing EOP) is forwarded as data with no meta pop. Recovery is by reset only.
- Reset mid-packet discards state. Downstream sees no EOP.

Decomposition:
- Package struct_s: metadata_t, PROT_UDP (existing), plus new sched_state_t enum {IDLE, BODY, BUBBLE}.
- Sub-module: shift_credit_ctr. It owns the saturating counter, credit_err and the need comparison.
- Top level holds the FSM and output registers.

Test Plan:
- TCP 3 flits, last empty=4, CREDITS=32 → out flits at t+1..t+3; in_pkt_ready=0 the cycle after EOP accept; credit_cnt 32→28.
- UDP 3 flits, last empty=4 → no bubble; back-to-back next SOP accepted next cycle; credit_cnt 32→29.
- TCP EOP empty=8 vs empty=7 → empty=8: need=1, no bubble; empty=7: need=2, bubble cycle present.
- SOP valid, in_meta_valid rises 3 cycles later → ready=0 for 3 cycles; out_pkt_sop and out_meta_valid high together 1 cycle after meta arrives; in_meta_ready pulses once.
- CREDITS=2, TCP 1-flit empty=2 → accepted, credit_cnt=0; next SOP stalls until 1 credit_return (1-flit UDP) or 2 returns (TCP empty<8).
- credit_return with accept of need=1 at credit_cnt=5 → stays 5. Return at credit_cnt=CREDITS idle → credit_err=1, sticky until rst; assert rst mid-BODY → outputs 0 immediately.
